// File: rtl/firc_result_rx.sv
// firc_result_rx: receive side of the firc PushOut/FI/FQ interface.
// Rounds and saturates each I/Q result, buffers it in a FWFT FIFO and
// drains it over a valid/ready port with frame (OutLast) marking.
//
// state    | meaning
// ST_EMPTY | no entries, OutValid low
// ST_PART  | 1..DEPTH-1 entries
// ST_FULL  | DEPTH entries, a stage write without a read is dropped
module firc_result_rx #(
  parameter int DEPTH     = 8,
  parameter int OUT_W     = 24,
  parameter int SHIFT     = 8,
  parameter int FRAME_LEN = 16
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     PushOut,
  input  logic [31:0]              FI,
  input  logic [31:0]              FQ,
  output logic                     StopUp,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [OUT_W-1:0]         OutI,
  output logic [OUT_W-1:0]         OutQ,
  output logic                     OutLast,
  output logic [$clog2(DEPTH):0]   Level,
  output logic                     Overflow,
  input  logic                     ClrOvf
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic signed [32:0] HALF = 33'sd1 <<< (SHIFT - 1);
  localparam logic signed [32:0] MAXV = (33'sd1 <<< (OUT_W - 1)) - 33'sd1;
  localparam logic signed [32:0] MINV = -(33'sd1 <<< (OUT_W - 1));

  typedef enum logic [1:0] {ST_EMPTY, ST_PART, ST_FULL} state_t;

  state_t                 state, state_nxt;
  logic                   stg_valid;
  logic [OUT_W-1:0]       stg_i, stg_q;
  logic [2*OUT_W-1:0]     mem [DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [LW-1:0]          level;
  logic [CW-1:0]          frame_cnt;
  logic                   xfer, wr_en, drop;
  logic [LW:0]            occ;

  // Round-half-up, arithmetic shift, then clamp to the signed output range.
  function automatic logic [OUT_W-1:0] rnd_sat(input logic [31:0] x);
    logic signed [32:0] sum;
    logic signed [32:0] shr;
    sum = $signed({x[31], x}) + HALF;
    shr = sum >>> SHIFT;
    if (shr > MAXV)      shr = MAXV;
    else if (shr < MINV) shr = MINV;
    return shr[OUT_W-1:0];
  endfunction

  assign OutValid = (state != ST_EMPTY);
  assign xfer     = OutValid & OutReady;
  // A full FIFO can still accept the stage entry if the head leaves this cycle.
  assign wr_en    = stg_valid & ((state != ST_FULL) | xfer);
  assign drop     = stg_valid & (state == ST_FULL) & ~xfer;
  assign OutI     = OutValid ? mem[rd_ptr][2*OUT_W-1:OUT_W] : '0;
  assign OutQ     = OutValid ? mem[rd_ptr][OUT_W-1:0] : '0;
  assign OutLast  = OutValid & (frame_cnt == CW'(FRAME_LEN - 1));
  assign Level    = level;
  assign occ      = {1'b0, level} + {{LW{1'b0}}, stg_valid};
  assign StopUp   = (occ >= (LW + 1)'(DEPTH - 2));

  // Stage 1: capture rounded/saturated result on each firc strobe.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stg_valid <= 1'b0;
      stg_i     <= '0;
      stg_q     <= '0;
    end else begin
      stg_valid <= PushOut;
      if (PushOut) begin
        stg_i <= rnd_sat(FI);
        stg_q <= rnd_sat(FQ);
      end
    end
  end

  // FIFO storage; contents are masked at the output while empty, so no reset needed.
  always_ff @(posedge Clk) begin
    if (wr_en) mem[wr_ptr] <= {stg_i, stg_q};
  end

  // Pointers, level, frame counter and sticky overflow.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      frame_cnt <= '0;
      Overflow  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (xfer)  rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !xfer)      level <= level + 1'b1;
      else if (!wr_en && xfer) level <= level - 1'b1;
      if (xfer) frame_cnt <= OutLast ? '0 : frame_cnt + 1'b1;
      if (drop)        Overflow <= 1'b1;
      else if (ClrOvf) Overflow <= 1'b0;
    end
  end

  // Occupancy state register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= ST_EMPTY;
    else       state <= state_nxt;
  end

  // Occupancy next-state; simultaneous write and read keeps the state.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (wr_en) state_nxt = ST_PART;
      ST_PART: begin
        if (wr_en && !xfer && level == LW'(DEPTH - 1)) state_nxt = ST_FULL;
        else if (xfer && !wr_en && level == LW'(1))    state_nxt = ST_EMPTY;
      end
      ST_FULL:  if (xfer && !wr_en) state_nxt = ST_PART;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

endmodule

// File: tb/tb_firc_result_rx.sv
// Directed bench for firc_result_rx with default parameters.
module tb_firc_result_rx;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        PushOut = 1'b0;
  logic [31:0] FI = '0;
  logic [31:0] FQ = '0;
  logic        StopUp;
  logic        OutValid;
  logic        OutReady = 1'b0;
  logic [23:0] OutI;
  logic [23:0] OutQ;
  logic        OutLast;
  logic [3:0]  Level;
  logic        Overflow;
  logic        ClrOvf = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  firc_result_rx #(.DEPTH(8), .OUT_W(24), .SHIFT(8), .FRAME_LEN(16)) dut (
    .Clk(Clk), .Reset(Reset), .PushOut(PushOut), .FI(FI), .FQ(FQ),
    .StopUp(StopUp), .OutValid(OutValid), .OutReady(OutReady),
    .OutI(OutI), .OutQ(OutQ), .OutLast(OutLast), .Level(Level),
    .Overflow(Overflow), .ClrOvf(ClrOvf)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    PushOut = 1'b0; OutReady = 1'b0; ClrOvf = 1'b0;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  // One result per cycle whose rounded values are +k / -k.
  task automatic push_k(input int k);
    PushOut = 1'b1;
    FI = 32'(k) << 8;
    FQ = -(32'(k) << 8);
    tick();
    PushOut = 1'b0;
  endtask

  task automatic push_raw(input logic [31:0] i, input logic [31:0] q);
    PushOut = 1'b1; FI = i; FQ = q;
    tick();
    PushOut = 1'b0;
  endtask

  // Pushes n results throttled by StopUp, checking order and frame marks.
  task automatic stream(input int n, input bit rnd);
    int pushed = 0;
    int got = 0;
    int cyc = 0;
    logic [23:0] q_exp;
    while (got < n && cyc < 2000) begin
      if (pushed < n && !StopUp) begin
        pushed++;
        PushOut = 1'b1;
        FI = 32'(pushed) << 8;
        FQ = -(32'(pushed) << 8);
      end else begin
        PushOut = 1'b0;
      end
      OutReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (OutValid && OutReady) begin
        got++;
        q_exp = 24'(-got);
        chk("stream_i", 32'(OutI), 32'(got));
        chk("stream_q", 32'(OutQ), 32'(q_exp));
        chk("stream_last", 32'(OutLast), 32'((got % 16) == 0));
      end
      @(posedge Clk);
      #1;
      cyc++;
    end
    PushOut = 1'b0;
    OutReady = 1'b0;
    chk("stream_done", 32'(got), 32'(n));
    chk("stream_ovf", 32'(Overflow), 32'd0);
  endtask

  initial begin
    #1;
    chk("rst_valid", 32'(OutValid), 32'd0);
    chk("rst_level", 32'(Level), 32'd0);
    chk("rst_ovf", 32'(Overflow), 32'd0);
    chk("rst_stop", 32'(StopUp), 32'd0);
    chk("rst_last", 32'(OutLast), 32'd0);
    chk("rst_outi", 32'(OutI), 32'd0);
    do_reset();

    // Rounding and latency
    push_raw(32'h0000_0180, 32'hFFFF_FE80);
    chk("lat_n1_valid", 32'(OutValid), 32'd0);
    tick();
    chk("lat_n2_valid", 32'(OutValid), 32'd1);
    chk("round_i", 32'(OutI), 32'h0000_0002);
    chk("round_q", 32'(OutQ), 32'h00FF_FFFF);
    chk("round_level", 32'(Level), 32'd1);
    OutReady = 1'b1; tick(); OutReady = 1'b0;
    chk("pop_level", 32'(Level), 32'd0);

    // Saturation
    do_reset();
    push_raw(32'h7FFF_FFFF, 32'h8000_0000);
    tick();
    chk("sat_i", 32'(OutI), 32'h007F_FFFF);
    chk("sat_q", 32'(OutQ), 32'h0080_0000);

    // Overflow with sink stalled
    do_reset();
    for (int j = 1; j <= 10; j++) begin
      push_k(j);
      if (j <= 8) chk("ovf_stopup", 32'(StopUp), 32'(j >= 6));
    end
    tick();
    chk("ovf_level", 32'(Level), 32'd8);
    chk("ovf_flag", 32'(Overflow), 32'd1);
    chk("ovf_stopup_full", 32'(StopUp), 32'd1);
    OutReady = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk("drain_valid", 32'(OutValid), 32'd1);
      chk("drain_i", 32'(OutI), 32'(k));
      chk("drain_last", 32'(OutLast), 32'd0);
      tick();
    end
    OutReady = 1'b0;
    chk("drain_empty", 32'(OutValid), 32'd0);
    chk("drain_level", 32'(Level), 32'd0);
    chk("ovf_sticky", 32'(Overflow), 32'd1);
    ClrOvf = 1'b1; tick(); ClrOvf = 1'b0;
    chk("ovf_clr", 32'(Overflow), 32'd0);

    // Full with simultaneous write and read
    do_reset();
    for (int j = 1; j <= 8; j++) push_k(j);
    tick();
    chk("full_level", 32'(Level), 32'd8);
    push_k(9);
    OutReady = 1'b1; tick(); OutReady = 1'b0;
    chk("full_rw_level", 32'(Level), 32'd8);
    chk("full_rw_ovf", 32'(Overflow), 32'd0);
    chk("full_rw_head", 32'(OutI), 32'd2);

    // Frame marking with random backpressure
    do_reset();
    stream(40, 1'b1);

    // Reset mid-drain
    do_reset();
    for (int j = 1; j <= 10; j++) push_k(j);
    tick();
    OutReady = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    OutReady = 1'b0;
    chk("mid_level", 32'(Level), 32'd5);
    chk("mid_ovf", 32'(Overflow), 32'd1);
    Reset = 1'b1;
    #2;
    chk("mid_rst_valid", 32'(OutValid), 32'd0);
    chk("mid_rst_level", 32'(Level), 32'd0);
    chk("mid_rst_ovf", 32'(Overflow), 32'd0);
    tick();
    Reset = 1'b0;
    stream(17, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
